// File: rtl/dmi_host_bridge.sv
// Host-command to RISC-V DMI request/response bridge. One transaction is in flight at a time.
// A request-to-response timeout turns a missing DMI response into a busy/timeout host response.
module dmi_host_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_cmd_valid_i,
    output logic        host_cmd_ready_o,
    input  logic        host_cmd_wr_i,
    input  logic [6:0]  host_cmd_addr_i,
    input  logic [31:0] host_cmd_wdata_i,
    output logic        host_rsp_valid_o,
    input  logic        host_rsp_ready_i,
    output logic [31:0] host_rsp_rdata_o,
    output logic [1:0]  host_rsp_status_o,
    output logic        host_rsp_timeout_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [1:0]  dmi_req_op_o,
    output logic [6:0]  dmi_req_addr_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_resp_i,
    output logic        busy_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_HOST
    } state_e;

    state_e        state_q, state_d;
    logic          wr_q, wr_d;
    logic [6:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    status_q, status_d;
    logic          tmo_q, tmo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired;
    logic [CW-1:0] cnt_inc;

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX);
    // Saturate at the limit so a long stall can never wrap back into range.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (host_cmd_valid_i) begin
                    wr_d    = host_cmd_wr_i;
                    addr_d  = host_cmd_addr_i;
                    wdata_d = host_cmd_wdata_i;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (dmi_req_ready_i) begin
                    state_d = S_RESP;
                end else if (expired) begin
                    rdata_d  = '0;
                    status_d = ST_BUSY;
                    tmo_d    = 1'b1;
                    state_d  = S_HOST;
                end
            end
            S_RESP: begin
                cnt_d = cnt_inc;
                // A response arriving on the expiry cycle still counts as a normal completion.
                if (dmi_resp_valid_i) begin
                    rdata_d  = dmi_resp_data_i;
                    status_d = dmi_resp_resp_i;
                    tmo_d    = 1'b0;
                    state_d  = S_HOST;
                end else if (expired) begin
                    rdata_d  = '0;
                    status_d = ST_BUSY;
                    tmo_d    = 1'b1;
                    state_d  = S_HOST;
                end
            end
            S_HOST: begin
                if (host_rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign host_cmd_ready_o   = (state_q == S_IDLE);
    assign busy_o             = (state_q != S_IDLE);
    assign dmi_req_valid_o    = (state_q == S_REQ);
    assign dmi_req_op_o       = (state_q == S_REQ) ? (wr_q ? OP_WRITE : OP_READ) : OP_NOP;
    assign dmi_req_addr_o     = addr_q;
    assign dmi_req_data_o     = wdata_q;
    // Ready in IDLE too, so late responses to timed-out or reset-aborted requests are drained.
    assign dmi_resp_ready_o   = (state_q == S_IDLE) || (state_q == S_RESP);
    assign host_rsp_valid_o   = (state_q == S_HOST);
    assign host_rsp_rdata_o   = rdata_q;
    assign host_rsp_status_o  = status_q;
    assign host_rsp_timeout_o = tmo_q;

endmodule

// File: tb/tb_dmi_host_bridge.sv
// Scoreboard bench for dmi_host_bridge: directed transactions push expected DMI requests and
// host responses into queues; a negedge monitor pops and compares on every handshake.
module tb_dmi_host_bridge;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_cmd_valid, host_cmd_ready, host_cmd_wr;
    logic [6:0]  host_cmd_addr;
    logic [31:0] host_cmd_wdata;
    logic        host_rsp_valid, host_rsp_ready;
    logic [31:0] host_rsp_rdata;
    logic [1:0]  host_rsp_status;
    logic        host_rsp_timeout;
    logic        dmi_req_valid, dmi_req_ready;
    logic [1:0]  dmi_req_op;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_resp;
    logic        busy;

    typedef struct packed {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  status;
        logic        tmo;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    int   vecs = 0;
    int   errs = 0;

    dmi_host_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .host_cmd_valid_i   (host_cmd_valid),
        .host_cmd_ready_o   (host_cmd_ready),
        .host_cmd_wr_i      (host_cmd_wr),
        .host_cmd_addr_i    (host_cmd_addr),
        .host_cmd_wdata_i   (host_cmd_wdata),
        .host_rsp_valid_o   (host_rsp_valid),
        .host_rsp_ready_i   (host_rsp_ready),
        .host_rsp_rdata_o   (host_rsp_rdata),
        .host_rsp_status_o  (host_rsp_status),
        .host_rsp_timeout_o (host_rsp_timeout),
        .dmi_req_valid_o    (dmi_req_valid),
        .dmi_req_ready_i    (dmi_req_ready),
        .dmi_req_op_o       (dmi_req_op),
        .dmi_req_addr_o     (dmi_req_addr),
        .dmi_req_data_o     (dmi_req_data),
        .dmi_resp_valid_i   (dmi_resp_valid),
        .dmi_resp_ready_o   (dmi_resp_ready),
        .dmi_resp_data_i    (dmi_resp_data),
        .dmi_resp_resp_i    (dmi_resp_resp),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every output at its reset value: only the two ready outputs high.
    task automatic chk_reset_outs(input string name);
        @(negedge clk);
        chk(name, {host_cmd_ready, host_rsp_valid, host_rsp_rdata, host_rsp_status, host_rsp_timeout,
                   dmi_req_valid, dmi_req_op, dmi_req_addr, dmi_req_data, dmi_resp_ready, busy},
                  {1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 2'd0, 7'h0, 32'h0, 1'b1, 1'b0});
    endtask

    // Present one command for one cycle; returns just after the accepting edge (DUT in REQ).
    task automatic send_cmd(input logic wr, input logic [6:0] addr, input logic [31:0] wdata);
        host_cmd_valid = 1'b1;
        host_cmd_wr    = wr;
        host_cmd_addr  = addr;
        host_cmd_wdata = wdata;
        @(negedge clk);
        chk("cmd_ready_idle", host_cmd_ready, 1'b1);
        step();
        host_cmd_valid = 1'b0;
    endtask

    // Monitor: compare every DMI request handshake and every host response handshake.
    always @(negedge clk) begin
        if (dmi_req_valid && dmi_req_ready) begin
            if (exp_req_q.size() == 0) begin
                chk("unexpected_dmi_req", 1'b1, 1'b0);
            end else begin
                chk("dmi_req", {dmi_req_op, dmi_req_addr, dmi_req_data}, exp_req_q.pop_front());
            end
        end
        if (host_rsp_valid && host_rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
                chk("unexpected_host_rsp", 1'b1, 1'b0);
            end else begin
                chk("host_rsp", {host_rsp_rdata, host_rsp_status, host_rsp_timeout}, exp_rsp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst            = 1'b1;
        host_cmd_valid = 1'b0;
        host_cmd_wr    = 1'b0;
        host_cmd_addr  = '0;
        host_cmd_wdata = '0;
        host_rsp_ready = 1'b1;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = '0;
        dmi_resp_resp  = '0;
        step();
        step();
        chk_reset_outs("reset_outputs");
        rst = 1'b0;
        step();

        // Read: request the cycle after acceptance, host response one cycle after DMI response.
        exp_req_q.push_back('{op: 2'd1, addr: 7'h11, data: 32'h0});
        exp_rsp_q.push_back('{rdata: 32'h00400082, status: 2'd0, tmo: 1'b0});
        send_cmd(1'b0, 7'h11, 32'h0);
        dmi_req_ready = 1'b1;
        @(negedge clk);
        chk("read_req_next_cycle", {dmi_req_valid, dmi_req_op, dmi_req_addr, busy}, {1'b1, 2'd1, 7'h11, 1'b1});
        step();
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h00400082;
        dmi_resp_resp  = 2'd0;
        @(negedge clk);
        chk("read_resp_state", {dmi_resp_ready, dmi_req_valid, dmi_req_op, host_rsp_valid}, {1'b1, 1'b0, 2'd0, 1'b0});
        step();
        dmi_resp_valid = 1'b0;
        @(negedge clk);
        chk("read_rsp_latency", host_rsp_valid, 1'b1);
        step();

        // Write with a 5-cycle request stall; fields must hold steady, one handshake only.
        exp_req_q.push_back('{op: 2'd2, addr: 7'h10, data: 32'h00000001});
        exp_rsp_q.push_back('{rdata: 32'hDEADBEEF, status: 2'd0, tmo: 1'b0});
        send_cmd(1'b1, 7'h10, 32'h00000001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("write_stall_stable", {dmi_req_valid, dmi_req_op, dmi_req_addr, dmi_req_data, dmi_resp_ready},
                                      {1'b1, 2'd2, 7'h10, 32'h00000001, 1'b0});
            step();
        end
        dmi_req_ready = 1'b1;
        step();
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'hDEADBEEF;
        step();
        dmi_resp_valid = 1'b0;
        step();

        // Timeout: no request handshake; expiry after TMO+1 cycles in REQ.
        exp_rsp_q.push_back('{rdata: 32'h0, status: 2'd3, tmo: 1'b1});
        send_cmd(1'b0, 7'h04, 32'h0);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (host_rsp_valid) break;
            step();
            n++;
        end
        chk("timeout_latency", n, TMO + 1);
        chk("timeout_req_dropped", {dmi_req_valid, dmi_req_op, busy}, {1'b0, 2'd0, 1'b1});
        step();
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h00001234;
        @(negedge clk);
        chk("late_resp_drained", {dmi_resp_ready, busy}, {1'b1, 1'b0});
        step();
        dmi_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_resp_no_host_rsp", {host_rsp_valid, busy, host_cmd_ready}, {1'b0, 1'b0, 1'b1});
            step();
        end

        // Host backpressure for 10 cycles on a failed-status response.
        exp_req_q.push_back('{op: 2'd1, addr: 7'h05, data: 32'h0});
        exp_rsp_q.push_back('{rdata: 32'hA5A50F0F, status: 2'd2, tmo: 1'b0});
        host_rsp_ready = 1'b0;
        send_cmd(1'b0, 7'h05, 32'h0);
        dmi_req_ready = 1'b1;
        step();
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'hA5A50F0F;
        dmi_resp_resp  = 2'd2;
        step();
        dmi_resp_valid = 1'b0;
        dmi_resp_resp  = 2'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("backpressure_hold",
                {host_rsp_valid, host_rsp_rdata, host_rsp_status, host_rsp_timeout, host_cmd_ready, busy, dmi_resp_ready},
                {1'b1, 32'hA5A50F0F, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0});
            step();
        end
        host_rsp_ready = 1'b1;
        step();

        // Request accepted immediately, response arrives on the exact expiry cycle.
        exp_req_q.push_back('{op: 2'd1, addr: 7'h22, data: 32'h0});
        exp_rsp_q.push_back('{rdata: 32'h0BADF00D, status: 2'd0, tmo: 1'b0});
        send_cmd(1'b0, 7'h22, 32'h0);
        dmi_req_ready = 1'b1;
        step();
        dmi_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) step();
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h0BADF00D;
        @(negedge clk);
        chk("expiry_still_waiting", {dmi_resp_ready, host_rsp_valid}, {1'b1, 1'b0});
        step();
        dmi_resp_valid = 1'b0;
        @(negedge clk);
        chk("expiry_handshake_wins", {host_rsp_valid, host_rsp_timeout, host_rsp_status}, {1'b1, 1'b0, 2'd0});
        step();

        // Reset while waiting in RESP: abort, no host response, later response drained.
        exp_req_q.push_back('{op: 2'd1, addr: 7'h30, data: 32'h0});
        send_cmd(1'b0, 7'h30, 32'h0);
        dmi_req_ready = 1'b1;
        step();
        dmi_req_ready = 1'b0;
        rst = 1'b1;
        step();
        chk_reset_outs("reset_in_resp");
        rst = 1'b0;
        step();
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h0000FFFF;
        @(negedge clk);
        chk("post_reset_drain", {dmi_resp_ready, busy}, {1'b1, 1'b0});
        step();
        dmi_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_no_rsp", {host_rsp_valid, host_rsp_rdata, busy}, {1'b0, 32'h0, 1'b0});
            step();
        end

        chk("req_queue_drained", exp_req_q.size(), 0);
        chk("rsp_queue_drained", exp_rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmi_host_bridge.md
DMI_HOST_BRIDGE -- requirements
Module: dmi_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles allowed from DMI request issue to DMI response; 0 disables the timeout.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  in  1  clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 host_cmd_valid_i  in  1  host command valid.
REQ-006 host_cmd_ready_o  out  1  bridge accepts a command.
REQ-007 host_cmd_wr_i  in  1  1 = DMI write, 0 = DMI read.
REQ-008 host_cmd_addr_i  in  7  DMI register address.
REQ-009 host_cmd_wdata_i  in  32  DMI write data.
REQ-010 host_rsp_valid_o  out  1  response available to the host.
REQ-011 host_rsp_ready_i  in  1  host consumes the response.
REQ-012 host_rsp_rdata_o  out  32  held DMI read data.
REQ-013 host_rsp_status_o  out  2  DMI resp field: 0 success, 2 failed, 3 busy.
REQ-014 host_rsp_timeout_o  out  1  transaction aborted by timeout.
REQ-015 dmi_req_valid_o  out  1  DMI request valid toward the debug module.
REQ-016 dmi_req_ready_i  in  1  debug module accepts the request.
REQ-017 dmi_req_op_o  out  2  1 = READ, 2 = WRITE, 0 = NOP.
REQ-018 dmi_req_addr_o  out  7  latched address.
REQ-019 dmi_req_data_o  out  32  latched write data.
REQ-020 dmi_resp_valid_i  in  1  DMI response valid.
REQ-021 dmi_resp_ready_o  out  1  bridge accepts the DMI response.
REQ-022 dmi_resp_data_i  in  32  DMI response data.
REQ-023 dmi_resp_resp_i  in  2  DMI response status.
REQ-024 busy_o  out  1  high in every state except IDLE.

Function
REQ-025 SHALL implement the FSM states IDLE, REQ, RESP and HOST, with one transaction in flight at most.
REQ-026 IDLE: host_cmd_ready_o=1; on host_cmd_valid_i, SHALL latch wr/addr/wdata, clear the timeout counter and enter REQ, so dmi_req_valid_o rises the cycle after acceptance.
REQ-027 REQ: dmi_req_valid_o=1 and op/addr/data SHALL stay stable until dmi_req_ready_i; the handshake cycle moves to RESP.
REQ-028 dmi_req_op_o SHALL be 0 (NOP) whenever dmi_req_valid_o=0.
REQ-029 RESP: dmi_resp_ready_o=1; on dmi_resp_valid_i, SHALL register data and resp, set timeout flag=0 and enter HOST, so host_rsp_valid_o rises one cycle after the DMI response.
REQ-030 HOST: host_rsp_valid_o=1 with rdata, status and timeout held stable until host_rsp_ready_i, then return to IDLE; the next command is accepted no earlier than the following cycle.
REQ-031 The timeout counter SHALL increment every cycle in REQ and RESP, with width $clog2(TIMEOUT_CYCLES+1), saturating and never wrapping.
REQ-032 When the counter reaches TIMEOUT_CYCLES (nonzero) in REQ or RESP without the completing handshake, SHALL enter HOST with rdata=0, status=3, timeout=1 and dmi_req_valid_o dropped the next cycle.
REQ-033 If the completing handshake and timeout expiry coincide, the handshake SHALL win.
REQ-034 In IDLE, dmi_resp_ready_o SHALL be 1 so that stale responses from timed-out requests are drained and discarded without affecting outputs.
REQ-035 dmi_resp_ready_o SHALL be 0 in REQ and HOST.
REQ-036 rdata SHALL be captured for writes as well and passed through unchanged.

Reset
REQ-037 While rst_i is high, the FSM SHALL be in IDLE, the counter 0, and registered data/status/timeout 0.
REQ-038 During reset, host_cmd_ready_o=1, dmi_resp_ready_o=1, and all other outputs 0.
REQ-039 Reset asserted mid-transaction SHALL abort it at the next edge with no host response, and any later DMI response SHALL be drained per REQ-034.

Verification
REQ-040 Read: cmd wr=0 addr=0x11 -> DMI op=1 addr=0x11 the next cycle; resp data=0x00400082 resp=0 -> host rdata=0x00400082, status 0, timeout 0, one cycle later.
REQ-041 Write with stall: cmd wr=1 addr=0x10 wdata=0x00000001, dmi_req_ready_i low 5 cycles -> req fields stable all 5 cycles, single handshake, host status 0.
REQ-042 Timeout: TIMEOUT_CYCLES=8, no DMI response -> host_rsp_timeout_o=1, status 3, rdata 0; a late response in IDLE is consumed and no host_rsp_valid_o follows.
REQ-043 Backpressure: host_rsp_ready_i low 10 cycles -> response held, host_cmd_ready_o=0 and busy_o=1 throughout.
REQ-044 Boundary: handshake on the expiry cycle -> normal response, timeout 0; rst_i during RESP -> IDLE next edge, all outputs at reset values.
